// File: rtl/sdram_burst_arbiter.sv
// SDRAM command arbiter: schedules auto-refresh, write bursts and read bursts
// onto a shared SDRAM controller, with a periodic refresh timer and overrun flag.
module sdram_burst_arbiter #(
    parameter int unsigned REF_PERIOD = 750
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       init_end,
    input  logic [9:0] wr_fifo_num,
    input  logic [7:0] wr_burst_len,
    input  logic [9:0] rd_fifo_num,
    input  logic [7:0] rd_burst_len,
    input  logic       read_valid,
    input  logic       aref_end,
    input  logic       wr_end,
    input  logic       rd_end,
    output logic       aref_en,
    output logic       wr_en,
    output logic       rd_en,
    output logic [2:0] arb_state,
    output logic       aref_overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam logic [9:0] TMR_LAST = 10'(REF_PERIOD - 1);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] ref_cnt;
    logic       aref_pend;
    logic       last_grant_wr;
    logic       wr_pend;
    logic       rd_pend;
    logic       tmr_wrap;

    assign wr_pend  = (wr_burst_len != '0) && (wr_fifo_num >= {2'b00, wr_burst_len});
    assign rd_pend  = read_valid && (rd_burst_len != '0) && (rd_fifo_num < {2'b00, rd_burst_len});
    assign tmr_wrap = init_end && (ref_cnt == TMR_LAST);

    assign arb_state = state;

    always_comb begin
        state_nxt = state;
        if (!init_end) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = ARB;
                ARB: begin
                    // Refresh first; on a write/read tie, alternate against the last grant
                    if (aref_pend)
                        state_nxt = AREF;
                    else if (wr_pend && rd_pend)
                        state_nxt = last_grant_wr ? READ : WRITE;
                    else if (wr_pend)
                        state_nxt = WRITE;
                    else if (rd_pend)
                        state_nxt = READ;
                end
                AREF:  if (aref_end) state_nxt = ARB;
                WRITE: if (wr_end)   state_nxt = ARB;
                READ:  if (rd_end)   state_nxt = ARB;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            ref_cnt       <= '0;
            aref_pend     <= 1'b0;
            aref_overrun  <= 1'b0;
            last_grant_wr <= 1'b0;
            aref_en       <= 1'b0;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
        end else begin
            state   <= state_nxt;
            aref_en <= (state_nxt == AREF);
            wr_en   <= (state_nxt == WRITE);
            rd_en   <= (state_nxt == READ);

            if (!init_end || tmr_wrap)
                ref_cnt <= '0;
            else
                ref_cnt <= ref_cnt + 10'd1;

            // A wrap coinciding with refresh entry leaves the new request pending
            if (tmr_wrap)
                aref_pend <= 1'b1;
            else if (!init_end || (state == ARB && state_nxt == AREF))
                aref_pend <= 1'b0;

            if (tmr_wrap && aref_pend)
                aref_overrun <= 1'b1;

            if (state == ARB && state_nxt == WRITE)
                last_grant_wr <= 1'b1;
            else if (state == ARB && state_nxt == READ)
                last_grant_wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Scoreboard bench for sdram_burst_arbiter: stimulus pushes expected grants
// (kind, edge number); a monitor pops and checks every grant rising edge.
module tb_sdram_burst_arbiter;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       init_end = 1'b0;
    logic [9:0] wr_fifo_num = '0;
    logic [7:0] wr_burst_len = 8'd8;
    logic [9:0] rd_fifo_num = 10'd16;
    logic [7:0] rd_burst_len = 8'd8;
    logic       read_valid = 1'b0;
    logic       aref_end = 1'b0;
    logic       wr_end = 1'b0;
    logic       rd_end = 1'b0;
    logic       aref_en;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] arb_state;
    logic       aref_overrun;

    localparam int K_AREF  = 2;
    localparam int K_WRITE = 3;
    localparam int K_READ  = 4;

    typedef struct {
        int kind;
        int at_edge;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   base  = 0;

    sdram_burst_arbiter #(.REF_PERIOD(16)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .init_end     (init_end),
        .wr_fifo_num  (wr_fifo_num),
        .wr_burst_len (wr_burst_len),
        .rd_fifo_num  (rd_fifo_num),
        .rd_burst_len (rd_burst_len),
        .read_valid   (read_valid),
        .aref_end     (aref_end),
        .wr_end       (wr_end),
        .rd_end       (rd_end),
        .aref_en      (aref_en),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .arb_state    (arb_state),
        .aref_overrun (aref_overrun)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Grant monitor
    logic [2:0] g_now;
    logic [2:0] g_prev = 3'b000;
    int         got_kind;
    exp_t       e;

    initial begin
        forever begin
            @(negedge sys_clk);
            g_now = {aref_en, wr_en, rd_en};
            if ((g_now & ~g_prev) != 3'b000) begin
                got_kind = aref_en ? K_AREF : (wr_en ? K_WRITE : K_READ);
                total++;
                if ($countones(g_now) > 1) begin
                    bad++;
                    $display("FAIL grant_onehot: grants=%b at edge %0d, required at most one high", g_now, cyc);
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_unexpected: kind=%0d at edge %0d, required no grant", got_kind, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != got_kind || e.at_edge != cyc) begin
                        bad++;
                        $display("FAIL grant_seq: kind=%0d edge=%0d, required kind=%0d edge=%0d",
                                 got_kind, cyc, e.kind, e.at_edge);
                    end
                end
            end
            g_prev = g_now;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, cyc - base - 1);
        end
    endtask

    // Advance so that edge E_k (relative to the init_end sample E_0) has just occurred
    task automatic to_edge(input int k);
        for (int n = 0; n < 200 && cyc < base + 1 + k; n++) tick();
        if (cyc != base + 1 + k) begin
            total++;
            bad++;
            $display("FAIL edge_sync: at %0d, required %0d", cyc, base + 1 + k);
        end
    endtask

    task automatic push(input int kind, input int k);
        exp_t x;
        x.kind    = kind;
        x.at_edge = base + 1 + k;
        exp_q.push_back(x);
    endtask

    task automatic restart();
        sys_rst  = 1'b1;
        init_end = 1'b0;
        aref_end = 1'b0;
        wr_end   = 1'b0;
        rd_end   = 1'b0;
        tick();
        sys_rst  = 1'b0;
        init_end = 1'b1;
        base     = cyc;
    endtask

    initial begin
        // Reset state and IDLE hold
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
        tick();
        check("rst_state", arb_state, 0);
        check("rst_aref_en", aref_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_overrun", aref_overrun, 0);

        // Refresh timing with no traffic
        init_end = 1'b1;
        base = cyc;
        push(K_AREF, 16);
        to_edge(0);
        check("idle_to_arb", arb_state, 1);
        to_edge(15);
        check("aref_not_early", aref_en, 0);
        to_edge(16);
        check("aref_state", arb_state, 2);
        to_edge(18);
        aref_end = 1'b1;
        to_edge(19);
        aref_end = 1'b0;
        check("aref_drop", aref_en, 0);
        check("aref_back_arb", arb_state, 1);

        // Single write, non-matching ends, threshold boundaries
        wr_fifo_num = 10'd8;
        wr_burst_len = 8'd8;
        read_valid = 1'b0;
        restart();
        push(K_WRITE, 1);
        to_edge(1);
        check("wr_grant", wr_en, 1);
        check("wr_state", arb_state, 3);
        to_edge(2);
        rd_end = 1'b1;
        aref_end = 1'b1;
        to_edge(3);
        rd_end = 1'b0;
        aref_end = 1'b0;
        to_edge(4);
        check("wr_hold_foreign_end", wr_en, 1);
        wr_end = 1'b1;
        wr_fifo_num = 10'd7;
        to_edge(5);
        wr_end = 1'b0;
        check("wr_release", wr_en, 0);
        to_edge(9);
        check("wr_below_len", arb_state, 1);
        wr_burst_len = 8'd0;
        wr_fifo_num = 10'd0;
        read_valid = 1'b1;
        rd_fifo_num = 10'd8;
        rd_burst_len = 8'd8;
        to_edge(13);
        check("zero_len_and_rd_full", arb_state, 1);
        rd_fifo_num = 10'd7;
        push(K_READ, 14);
        to_edge(14);
        check("rd_one_below", rd_en, 1);
        rd_end = 1'b1;
        to_edge(15);
        rd_end = 1'b0;

        // Tie alternation with immediate completions
        wr_burst_len = 8'd8;
        wr_fifo_num = 10'd8;
        rd_fifo_num = 10'd0;
        rd_burst_len = 8'd8;
        read_valid = 1'b1;
        restart();
        for (int i = 0; i < 4; i++) begin
            push((i % 2 == 1) ? K_READ : K_WRITE, 1 + 2 * i);
            to_edge(1 + 2 * i);
            check("tie_state", arb_state, (i % 2 == 1) ? 4 : 3);
            wr_end = wr_en;
            rd_end = rd_en;
            to_edge(2 + 2 * i);
            wr_end = 1'b0;
            rd_end = 1'b0;
        end
        wr_fifo_num = 10'd0;
        read_valid = 1'b0;

        // Refresh deferred by a 20-cycle write, then wins over both requests
        wr_fifo_num = 10'd8;
        rd_fifo_num = 10'd0;
        restart();
        push(K_WRITE, 1);
        to_edge(15);
        check("wr_during_due", wr_en, 1);
        to_edge(20);
        wr_end = 1'b1;
        read_valid = 1'b1;
        to_edge(21);
        wr_end = 1'b0;
        check("wr_end_arb", arb_state, 1);
        push(K_AREF, 22);
        to_edge(22);
        check("aref_priority", arb_state, 2);
        aref_end = 1'b1;
        push(K_READ, 24);
        to_edge(23);
        aref_end = 1'b0;
        check("aref_done", arb_state, 1);
        to_edge(24);
        check("rd_after_aref", rd_en, 1);
        rd_end = 1'b1;
        wr_fifo_num = 10'd0;
        read_valid = 1'b0;
        to_edge(25);
        rd_end = 1'b0;
        check("rd_done", arb_state, 1);

        // Overrun, sticky across aref_end, cleared by reset mid-write
        restart();
        push(K_AREF, 16);
        to_edge(16);
        check("ovr_aref", aref_en, 1);
        to_edge(46);
        check("ovr_not_yet", aref_overrun, 0);
        to_edge(47);
        check("ovr_set", aref_overrun, 1);
        to_edge(49);
        aref_end = 1'b1;
        to_edge(50);
        aref_end = 1'b0;
        check("ovr_arb", arb_state, 1);
        push(K_AREF, 51);
        to_edge(51);
        aref_end = 1'b1;
        to_edge(52);
        aref_end = 1'b0;
        wr_fifo_num = 10'd8;
        check("ovr_sticky", aref_overrun, 1);
        push(K_WRITE, 53);
        to_edge(53);
        check("ovr_wr", wr_en, 1);
        to_edge(54);
        sys_rst = 1'b1;
        to_edge(55);
        check("midwr_rst_state", arb_state, 0);
        check("midwr_rst_wr_en", wr_en, 0);
        check("midwr_rst_aref_en", aref_en, 0);
        check("midwr_rst_rd_en", rd_en, 0);
        check("midwr_rst_overrun", aref_overrun, 0);
        wr_fifo_num = 10'd0;

        // init_end drop mid-read; timer restarts from re-init
        rd_fifo_num = 10'd0;
        rd_burst_len = 8'd8;
        read_valid = 1'b1;
        restart();
        push(K_READ, 1);
        to_edge(1);
        check("rd_grant", rd_en, 1);
        to_edge(3);
        init_end = 1'b0;
        to_edge(4);
        check("drop_rd_en", rd_en, 0);
        check("drop_state", arb_state, 0);
        to_edge(6);
        check("drop_hold_idle", arb_state, 0);
        init_end = 1'b1;
        to_edge(7);
        check("reinit_arb", arb_state, 1);
        push(K_READ, 8);
        to_edge(8);
        check("rd_regrant", rd_en, 1);
        rd_end = 1'b1;
        read_valid = 1'b0;
        to_edge(9);
        rd_end = 1'b0;
        check("rd_regrant_done", arb_state, 1);
        push(K_AREF, 23);
        to_edge(16);
        check("timer_cleared", aref_en, 0);
        to_edge(23);
        check("aref_after_reinit", aref_en, 1);
        to_edge(25);

        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
